// File: rtl/cpu6_fetchq_pkg.sv
// Shared defaults for the cpu6 decoupled fetch unit.
package cpu6_fetchq_pkg;

  localparam int unsigned CPU6_XLEN         = 32;
  localparam int unsigned CPU6_FETCHQ_DEPTH = 4;
  localparam logic [CPU6_XLEN-1:0] CPU6_RESET_PC = '0;
  localparam int unsigned CPU6_INSTR_BYTES  = 4;

endpackage

// File: rtl/cpu6_fetchq_buf.sv
// Prefetch queue storage: DEPTH entries of {pc, instr}, synchronous write,
// combinational read, cleared on reset.
module cpu6_fetchq_buf
  import cpu6_fetchq_pkg::*;
#(
  parameter int unsigned XLEN  = CPU6_XLEN,
  parameter int unsigned DEPTH = CPU6_FETCHQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_ptr,
  input  logic [2*XLEN-1:0] wr_data,
  input  logic [AW-1:0]     rd_ptr,
  output logic [2*XLEN-1:0] rd_data
);

  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [2*XLEN-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/cpu6_fetchq.sv
// Decoupled instruction fetch: PC generator with credit-based issue into a
// DEPTH-entry prefetch queue, drained by decode, flushed by redirect.
module cpu6_fetchq
  import cpu6_fetchq_pkg::*;
#(
  parameter int unsigned XLEN = CPU6_XLEN,
  parameter int unsigned DEPTH = CPU6_FETCHQ_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU6_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;

  logic            pop;
  logic            push;
  logic [AW+1:0]   occupancy;
  logic [2*XLEN-1:0] head;

  always_comb begin
    out_valid = !reset && (count_q != '0) && !redirect;
    pop       = out_valid && out_ready;
    push      = inflight_q && !redirect;
    // Entries held plus the one still returning, minus the slot freed now.
    occupancy = {1'b0, count_q} + (AW+2)'(inflight_q) - (AW+2)'(pop);
    imem_en   = !reset && (redirect || (occupancy < (AW+2)'(DEPTH)));
    imem_addr = redirect ? redirect_pc : fetch_pc_q;

    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc + XLEN'(CPU6_INSTR_BYTES);
      req_pc_d   = redirect_pc;
      inflight_d = 1'b1;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_en) begin
        fetch_pc_d = fetch_pc_q + XLEN'(CPU6_INSTR_BYTES);
        req_pc_d   = fetch_pc_q;
        inflight_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  cpu6_fetchq_buf #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_ptr  (wr_ptr_q),
    .wr_data ({req_pc_q, imem_rdata}),
    .rd_ptr  (rd_ptr_q),
    .rd_data (head)
  );

  assign out_pc    = head[2*XLEN-1:XLEN];
  assign out_instr = head[XLEN-1:0];

endmodule

// File: tb/tb_cpu6_fetchq.sv
// Bench for cpu6_fetchq at DEPTH 4, 2 and 8 driven by shared stimulus,
// each compared against a queue-based reference model.
module tb_cpu6_fetchq;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;

  logic        en   [3];
  logic [31:0] addr [3];
  logic [31:0] rdata[3];
  logic        ov   [3];
  logic [31:0] opc  [3];
  logic [31:0] oins [3];

  int passed = 0;
  int total  = 0;

  int          dep [3] = '{4, 2, 8};
  logic [31:0] mq  [3][$];
  logic [31:0] mfpc[3];
  logic [31:0] mipc[3];
  bit          minfl[3];
  bit          prev_rst = 1'b0;

  always #5 clk = ~clk;

  // Memory model: returns addr ^ K one cycle after the request.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rdata[i] <= addr[i] ^ K;
  end

  cpu6_fetchq #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_d4 (
    .clk(clk), .reset(reset), .imem_en(en[0]), .imem_addr(addr[0]),
    .imem_rdata(rdata[0]), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(ov[0]), .out_ready(out_ready), .out_pc(opc[0]), .out_instr(oins[0])
  );
  cpu6_fetchq #(.XLEN(32), .DEPTH(2), .RESET_PC(32'h0)) u_d2 (
    .clk(clk), .reset(reset), .imem_en(en[1]), .imem_addr(addr[1]),
    .imem_rdata(rdata[1]), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(ov[1]), .out_ready(out_ready), .out_pc(opc[1]), .out_instr(oins[1])
  );
  cpu6_fetchq #(.XLEN(32), .DEPTH(8), .RESET_PC(32'h0)) u_d8 (
    .clk(clk), .reset(reset), .imem_en(en[2]), .imem_addr(addr[2]),
    .imem_rdata(rdata[2]), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(ov[2]), .out_ready(out_ready), .out_pc(opc[2]), .out_instr(oins[2])
  );

  task automatic chk(input string tag, input int i, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s depth=%0d observed=%h expected=%h", tag, dep[i], obs, exp);
  endtask

  // One cycle: drive at negedge, compare after settling, advance model at posedge.
  task automatic step(input bit r, input bit rd, input bit ry, input logic [31:0] rp);
    bit          e_en [3];
    bit          e_pop[3];
    logic [31:0] e_addr[3];
    @(negedge clk);
    reset = r; redirect = rd; out_ready = ry; redirect_pc = rp;
    #1;
    for (int i = 0; i < 3; i++) begin
      bit e_val;
      int occ;
      e_val    = !r && (mq[i].size() != 0) && !rd;
      e_pop[i] = e_val && ry;
      occ      = mq[i].size() + int'(minfl[i]) - int'(e_pop[i]);
      e_en[i]  = !r && (rd || occ < dep[i]);
      e_addr[i] = rd ? rp : mfpc[i];
      chk("imem_en", i, {31'b0, en[i]}, {31'b0, e_en[i]});
      if (e_en[i]) chk("imem_addr", i, addr[i], e_addr[i]);
      chk("out_valid", i, {31'b0, ov[i]}, {31'b0, e_val});
      if (e_val) begin
        chk("out_pc", i, opc[i], mq[i][0]);
        chk("out_instr", i, oins[i], mq[i][0] ^ K);
      end
      if (r && prev_rst) begin
        chk("rst_out_pc", i, opc[i], 32'h0);
        chk("rst_out_instr", i, oins[i], 32'h0);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        mq[i].delete();
        mfpc[i]  = 32'h0;
        minfl[i] = 1'b0;
      end else if (rd) begin
        mq[i].delete();
        mfpc[i]  = rp + 32'd4;
        mipc[i]  = rp;
        minfl[i] = 1'b1;
      end else begin
        if (e_pop[i]) void'(mq[i].pop_front());
        if (minfl[i]) mq[i].push_back(mipc[i]);
        if (e_en[i]) begin
          mipc[i] = mfpc[i];
          mfpc[i] = mfpc[i] + 32'd4;
        end
        minfl[i] = e_en[i];
      end
    end
    prev_rst = r;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mfpc[i] = '0; mipc[i] = '0; minfl[i] = 1'b0;
    end

    // Reset, then stream with decode always ready.
    repeat (2) step(1, 0, 1, 32'h0);
    repeat (12) step(0, 0, 1, 32'h0);

    // Fill with decode stalled, release for one cycle, stall, then drain.
    repeat (2) step(1, 0, 0, 32'h0);
    repeat (8) step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h0);
    repeat (2) step(0, 0, 0, 32'h0);
    repeat (4) step(0, 0, 1, 32'h0);

    // Redirect with 3 queued + 1 inflight (DEPTH=4) and decode ready.
    repeat (2) step(1, 0, 0, 32'h0);
    repeat (4) step(0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h200);
    repeat (6) step(0, 0, 1, 32'h0);

    // Address wrap at the top of the address space.
    step(0, 1, 1, 32'hFFFF_FFFC);
    repeat (5) step(0, 0, 1, 32'h0);

    // Reset in the middle of a stream with a response inflight.
    repeat (3) step(0, 0, 1, 32'h0);
    step(1, 0, 1, 32'h0);
    repeat (6) step(0, 0, 1, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bit r, rd, ry;
      logic [31:0] rp;
      r  = ($urandom_range(0, 99) < 1);
      rd = ($urandom_range(0, 99) < 4);
      ry = ($urandom_range(0, 99) < 70);
      rp = $urandom & 32'hFFFF_FFFC;
      step(r, rd, ry, rp);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
